e_mdu: RTL and testbench

- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Consumes the D/E pipeline register outputs: operand 1 (rs value), operand 2 (rt value) and a decoded MDU opcode.
- Models multi-cycle latency with a busy counter.
- The hazard unit uses start|busy to stall the D stage on any MDU instruction (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).
- mfhi/mflo results feed the E-stage result mux toward the E/M register.

---
 rtl/e_mdu.sv | 143 ++++++++++++++
 tb/tb_e_mdu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs one mult/div at a time
// and publishes the result into HI/LO after a fixed busy latency.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_O1,
    input  logic [31:0] E_O2,
    input  logic [3:0]  E_MDU_OP,
    input  logic        E_VALID,
    output logic        E_START,
    output logic        E_BUSY,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_MDU_O
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    logic [3:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        op_ok;
    logic        is_mult;
    logic        is_arith;
    logic        div_zero;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;

    // Ops are only honoured for a real instruction while nothing is in flight.
    assign op_ok    = E_VALID && !busy_q;
    assign is_mult  = (E_MDU_OP == OP_MULT) || (E_MDU_OP == OP_MULTU);
    assign is_arith = is_mult || (E_MDU_OP == OP_DIV) || (E_MDU_OP == OP_DIVU);
    assign E_START  = op_ok && is_arith;
    assign div_zero = (E_O2 == 32'd0);

    // Signed divide works on magnitudes so the INT_MIN / -1 case wraps cleanly.
    always_comb begin
        prod_s = $signed({{32{E_O1[31]}}, E_O1}) * $signed({{32{E_O2[31]}}, E_O2});
        prod_u = {32'd0, E_O1} * {32'd0, E_O2};
        div_b  = div_zero ? 32'd1 : E_O2;
        mag_a  = E_O1[31] ? (32'd0 - E_O1) : E_O1;
        mag_b  = E_O2[31] ? (32'd0 - E_O2) : div_b;
        mag_q  = mag_a / mag_b;
        mag_r  = mag_a % mag_b;
    end

    always_comb begin
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        if (E_START) begin
            count_d   = is_mult ? MULT_CNT : DIV_CNT;
            pend_wr_d = 1'b1;
            case (E_MDU_OP)
                OP_MULT: begin
                    pend_hi_d = prod_s[63:32];
                    pend_lo_d = prod_s[31:0];
                end
                OP_MULTU: begin
                    pend_hi_d = prod_u[63:32];
                    pend_lo_d = prod_u[31:0];
                end
                OP_DIV: begin
                    pend_wr_d = !div_zero;
                    pend_lo_d = (E_O1[31] ^ E_O2[31]) ? (32'd0 - mag_q) : mag_q;
                    pend_hi_d = E_O1[31] ? (32'd0 - mag_r) : mag_r;
                end
                default: begin
                    pend_wr_d = !div_zero;
                    pend_lo_d = E_O1 / div_b;
                    pend_hi_d = E_O1 % div_b;
                end
            endcase
        end else if (count_q == 4'd1) begin
            count_d = 4'd0;
            if (pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end

        if (op_ok && (E_MDU_OP == OP_MTHI)) hi_d = E_O1;
        if (op_ok && (E_MDU_OP == OP_MTLO)) lo_d = E_O1;

        busy_d = (count_d != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign E_BUSY  = busy_q;
    assign E_HI    = hi_q;
    assign E_LO    = lo_q;
    assign E_MDU_O = (E_VALID && (E_MDU_OP == OP_MFHI)) ? hi_q :
                     (E_VALID && (E_MDU_OP == OP_MFLO)) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed test-plan scenarios followed by random traffic,
// every cycle compared against an arithmetic model of HI/LO and the busy window.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] E_O1;
    logic [31:0] E_O2;
    logic [3:0]  E_MDU_OP;
    logic        E_VALID;
    logic        E_START;
    logic        E_BUSY;
    logic [31:0] E_HI;
    logic [31:0] E_LO;
    logic [31:0] E_MDU_O;

    int errs   = 0;
    int checks = 0;

    // Reference model state
    int unsigned m_rem;
    bit [31:0]   m_hi, m_lo, m_phi, m_plo;
    bit          m_pok;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_O1     (E_O1),
        .E_O2     (E_O2),
        .E_MDU_OP (E_MDU_OP),
        .E_VALID  (E_VALID),
        .E_START  (E_START),
        .E_BUSY   (E_BUSY),
        .E_HI     (E_HI),
        .E_LO     (E_LO),
        .E_MDU_O  (E_MDU_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive, compare outputs against model, clock, advance model.
    task automatic step(input bit v, input bit [3:0] op, input bit [31:0] a,
                        input bit [31:0] b, input bit rst);
        bit     busy, start;
        bit [31:0] exp_o;
        longint sa, sb, sq, sr, p;
        longint unsigned pu;
        E_VALID  = v;
        E_MDU_OP = op;
        E_O1     = a;
        E_O2     = b;
        reset    = rst;
        #1;
        busy  = (m_rem != 0);
        start = v && (op >= 1) && (op <= 4) && !busy;
        exp_o = (v && op == 5) ? m_hi : (v && op == 6) ? m_lo : 32'd0;
        chk("start", {31'd0, E_START}, {31'd0, start});
        chk("busy",  {31'd0, E_BUSY},  {31'd0, busy});
        chk("mdu_o", E_MDU_O, exp_o);
        chk("hi",    E_HI, m_hi);
        chk("lo",    E_LO, m_lo);
        @(posedge clk);
        if (rst) begin
            m_rem = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0;
        end else if (start) begin
            m_pok = 1;
            case (op)
                4'd1: begin
                    sa = $signed(a); sb = $signed(b); p = sa * sb;
                    m_phi = p[63:32]; m_plo = p[31:0];
                end
                4'd2: begin
                    pu = longint'(a) * longint'(b);
                    m_phi = pu[63:32]; m_plo = pu[31:0];
                end
                4'd3: begin
                    if (b == 0) m_pok = 0;
                    else begin
                        sa = $signed(a); sb = $signed(b);
                        sq = sa / sb; sr = sa % sb;
                        m_plo = sq[31:0]; m_phi = sr[31:0];
                    end
                end
                default: begin
                    if (b == 0) m_pok = 0;
                    else begin
                        m_plo = a / b; m_phi = a % b;
                    end
                end
            endcase
            m_rem = (op <= 2) ? 5 : 10;
        end else begin
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0 && m_pok) begin
                    m_hi = m_phi; m_lo = m_plo;
                end
            end
            if (v && !busy && op == 7) m_hi = a;
            if (v && !busy && op == 8) m_lo = a;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        bit [3:0]  rop;
        bit [31:0] ra, rb;
        m_rem = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0;
        reset = 1'b1; E_VALID = 1'b0; E_MDU_OP = 4'd0; E_O1 = 32'd0; E_O2 = 32'd0;
        @(negedge clk);
        @(negedge clk);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        chk("rst_busy", {31'd0, E_BUSY}, 32'd0);
        chk("rst_hi", E_HI, 32'd0);
        chk("rst_lo", E_LO, 32'd0);

        // signed multiply
        step(1'b1, 4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        idle(5);
        chk("mult_hi", E_HI, 32'hFFFFFFFF);
        chk("mult_lo", E_LO, 32'hFFFFFFFA);
        chk("mult_busy", {31'd0, E_BUSY}, 32'd0);

        // unsigned multiply
        step(1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        idle(4);
        chk("multu_hold_lo", E_LO, 32'hFFFFFFFA);
        idle(1);
        chk("multu_hi", E_HI, 32'hFFFFFFFE);
        chk("multu_lo", E_LO, 32'h00000001);

        // signed divide
        step(1'b1, 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        idle(10);
        chk("div_lo", E_LO, 32'hFFFFFFFD);
        chk("div_hi", E_HI, 32'hFFFFFFFF);

        // divide by zero keeps HI/LO
        step(1'b1, 4'd7, 32'h11, 32'd0, 1'b0);
        step(1'b1, 4'd8, 32'h22, 32'd0, 1'b0);
        step(1'b1, 4'd3, 32'd1234, 32'd0, 1'b0);
        idle(9);
        chk("dz_busy9", {31'd0, E_BUSY}, 32'd1);
        idle(1);
        chk("dz_hi", E_HI, 32'h11);
        chk("dz_lo", E_LO, 32'h22);
        chk("dz_busy", {31'd0, E_BUSY}, 32'd0);

        // INT_MIN / -1
        step(1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        idle(10);
        chk("ovf_lo", E_LO, 32'h80000000);
        chk("ovf_hi", E_HI, 32'h0);

        // mthi then mfhi/mflo
        step(1'b1, 4'd7, 32'hDEADBEEF, 32'd0, 1'b0);
        step(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
        chk("mflo_o", E_MDU_O, 32'h80000000);
        step(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
        chk("mfhi_o", E_MDU_O, 32'hDEADBEEF);

        // interlock: mtlo and mult while busy are ignored
        step(1'b1, 4'd1, 32'd6, 32'd7, 1'b0);
        step(1'b1, 4'd8, 32'h55, 32'd0, 1'b0);
        step(1'b1, 4'd1, 32'd100, 32'd100, 1'b0);
        idle(2);
        chk("ilk_busy", {31'd0, E_BUSY}, 32'd1);
        idle(1);
        chk("ilk_lo", E_LO, 32'd42);
        chk("ilk_hi", E_HI, 32'd0);
        chk("ilk_done", {31'd0, E_BUSY}, 32'd0);

        // back-to-back start sees updated HI/LO
        step(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
        chk("b2b_mflo", E_MDU_O, 32'd42);

        // reset mid-divide
        step(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
        idle(3);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        chk("rmid_busy", {31'd0, E_BUSY}, 32'd0);
        chk("rmid_hi", E_HI, 32'd0);
        chk("rmid_lo", E_LO, 32'd0);
        idle(12);
        chk("rmid_late_hi", E_HI, 32'd0);
        chk("rmid_late_lo", E_LO, 32'd0);

        // bubble with mult opcode
        step(1'b0, 4'd1, 32'd3, 32'd4, 1'b0);
        chk("bub_busy", {31'd0, E_BUSY}, 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom();
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
            step($urandom_range(0, 4) != 0, rop, ra, rb, $urandom_range(0, 99) == 0);
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
